// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep sequencer for the NCO core: primes the core until out_valid,
// then steps phi_inc from start toward stop, holding each value for a programmable dwell.
module nco_sweep_ctrl #(
    parameter int unsigned APR      = 32,
    parameter int unsigned DWELL_W  = 16,
    parameter int unsigned PRIME_TO = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [APR-1:0]     cfg_start,
    input  logic [APR-1:0]     cfg_stop,
    input  logic [APR-1:0]     cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_mode,
    input  logic               start,
    input  logic               abort,
    input  logic               nco_out_valid,
    output logic               nco_clken,
    output logic [APR-1:0]     nco_phi_inc,
    output logic               busy,
    output logic               sweep_done,
    output logic               sweep_wrap,
    output logic               err
);

    localparam int unsigned WD_W = (PRIME_TO > 1) ? $clog2(PRIME_TO) : 1;

    typedef struct packed {
        logic [APR-1:0]     start;
        logic [APR-1:0]     stop;
        logic [APR-1:0]     step;
        logic [DWELL_W-1:0] dwell;
        logic               mode;
        logic               up;
    } sweep_cfg_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_SWEEP = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    sweep_cfg_t         cfg_q, cfg_d;
    logic               loaded_q, loaded_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               clken_q, clken_d;
    logic [APR-1:0]     phi_q, phi_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               wrap_q, wrap_d;
    logic               err_q, err_d;

    logic               accept;
    logic [DWELL_W-1:0] dwell_rld;
    logic [APR:0]       inc_up;
    logic [APR:0]       inc_dn;
    logic               clamp;
    logic [APR-1:0]     next_inc;

    assign cfg_ready = (state_q == S_IDLE);
    assign accept    = cfg_valid && cfg_ready;
    // A programmed dwell of 0 behaves as a dwell of 1
    assign dwell_rld = (cfg_q.dwell == '0) ? '0 : DWELL_W'(cfg_q.dwell - DWELL_W'(1));

    // Next increment in APR+1 bits so overflow/underflow clamps to stop
    always_comb begin
        inc_up   = {1'b0, phi_q} + {1'b0, cfg_q.step};
        inc_dn   = {1'b0, phi_q} - {1'b0, cfg_q.step};
        clamp    = 1'b0;
        next_inc = phi_q;
        if (cfg_q.up) begin
            clamp    = (inc_up >= {1'b0, cfg_q.stop});
            next_inc = clamp ? cfg_q.stop : inc_up[APR-1:0];
        end else begin
            clamp    = inc_dn[APR] || (inc_dn[APR-1:0] <= cfg_q.stop);
            next_inc = clamp ? cfg_q.stop : inc_dn[APR-1:0];
        end
    end

    // Sequencer next-state and registered-output decode
    always_comb begin
        state_d  = state_q;
        cfg_d    = cfg_q;
        loaded_d = loaded_q;
        wd_d     = wd_q;
        dwell_d  = dwell_q;
        phi_d    = phi_q;
        err_d    = err_q;
        done_d   = 1'b0;
        wrap_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cfg_d.start = cfg_start;
                    cfg_d.stop  = cfg_stop;
                    cfg_d.step  = cfg_step;
                    cfg_d.dwell = cfg_dwell;
                    cfg_d.mode  = cfg_mode;
                    cfg_d.up    = (cfg_start <= cfg_stop);
                    loaded_d    = 1'b1;
                    err_d       = 1'b0;
                end else if (start && loaded_q) begin
                    state_d = S_PRIME;
                    phi_d   = cfg_q.start;
                    wd_d    = '0;
                end
            end
            S_PRIME: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (nco_out_valid) begin
                    state_d = S_SWEEP;
                    dwell_d = dwell_rld;
                end else if (wd_q == WD_W'(PRIME_TO - 1)) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_SWEEP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (dwell_q != '0) begin
                    dwell_d = dwell_q - DWELL_W'(1);
                end else begin
                    dwell_d = dwell_rld;
                    if (phi_q != cfg_q.stop) begin
                        phi_d = next_inc;
                    end else if (cfg_q.mode) begin
                        phi_d  = cfg_q.start;
                        wrap_d = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        clken_d = (state_d != S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cfg_q    <= '0;
            loaded_q <= 1'b0;
            wd_q     <= '0;
            dwell_q  <= '0;
            clken_q  <= 1'b0;
            phi_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wrap_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cfg_q    <= cfg_d;
            loaded_q <= loaded_d;
            wd_q     <= wd_d;
            dwell_q  <= dwell_d;
            clken_q  <= clken_d;
            phi_q    <= phi_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wrap_q   <= wrap_d;
            err_q    <= err_d;
        end
    end

    assign nco_clken   = clken_q;
    assign nco_phi_inc = phi_q;
    assign busy        = busy_q;
    assign sweep_done  = done_q;
    assign sweep_wrap  = wrap_q;
    assign err         = err_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Randomized self-checking bench for nco_sweep_ctrl against a list-based sweep model.
module tb_nco_sweep_ctrl;

    localparam int unsigned APR      = 32;
    localparam int unsigned DWELL_W  = 16;
    localparam int unsigned PRIME_TO = 64;

    logic               clk = 1'b0;
    logic               reset;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [APR-1:0]     cfg_start;
    logic [APR-1:0]     cfg_stop;
    logic [APR-1:0]     cfg_step;
    logic [DWELL_W-1:0] cfg_dwell;
    logic               cfg_mode;
    logic               start;
    logic               abort;
    logic               nco_out_valid;
    logic               nco_clken;
    logic [APR-1:0]     nco_phi_inc;
    logic               busy;
    logic               sweep_done;
    logic               sweep_wrap;
    logic               err;

    logic [5:0]  flg;
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    // Model of the accepted configuration and the distinct increments it visits
    longint ms, me, mst;
    int     md, mmode;
    logic   m_err;
    longint vals[$];
    bit     tone;

    nco_sweep_ctrl #(
        .APR      (APR),
        .DWELL_W  (DWELL_W),
        .PRIME_TO (PRIME_TO)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_start     (cfg_start),
        .cfg_stop      (cfg_stop),
        .cfg_step      (cfg_step),
        .cfg_dwell     (cfg_dwell),
        .cfg_mode      (cfg_mode),
        .start         (start),
        .abort         (abort),
        .nco_out_valid (nco_out_valid),
        .nco_clken     (nco_clken),
        .nco_phi_inc   (nco_phi_inc),
        .busy          (busy),
        .sweep_done    (sweep_done),
        .sweep_wrap    (sweep_wrap),
        .err           (err)
    );

    always #5 clk = ~clk;

    assign flg = {cfg_ready, busy, nco_clken, sweep_done, sweep_wrap, err};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] f_idle();
        return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, m_err};
    endfunction

    function automatic logic [5:0] f_run(input logic w);
        return {1'b0, 1'b1, 1'b1, 1'b0, w, m_err};
    endfunction

    function automatic logic [5:0] f_done();
        return {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, m_err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Distinct increments from start to stop with saturating steps
    function automatic void build_vals();
        longint v, nv;
        vals.delete();
        tone = 0;
        v = ms;
        if (mst == 0 && ms != me) begin
            vals.push_back(v);
            tone = 1;
            return;
        end
        while (vals.size() < 1000) begin
            vals.push_back(v);
            if (v == me) break;
            nv = (ms <= me) ? v + mst : v - mst;
            if ((ms <= me) ? (nv >= me) : (nv <= me)) v = me;
            else v = nv;
        end
    endfunction

    task automatic do_cfg(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                          input logic [15:0] dw, input logic md_i, input logic with_start);
        cfg_valid = 1'b1;
        cfg_start = s;
        cfg_stop  = e;
        cfg_step  = st;
        cfg_dwell = dw;
        cfg_mode  = md_i;
        start     = with_start;
        tick();
        cfg_valid = 1'b0;
        start     = 1'b0;
        cfg_start = $urandom;
        cfg_stop  = $urandom;
        cfg_step  = $urandom;
        ms    = {32'd0, s};
        me    = {32'd0, e};
        mst   = {32'd0, st};
        md    = (dw == 16'd0) ? 1 : int'(dw);
        mmode = int'(md_i);
        m_err = 1'b0;
        build_vals();
        check_eq("cfg_accept_flags", 64'(flg), 64'(f_idle()));
    endtask

    task automatic run_sweep(input int p, input int abort_at, input bit junk);
        int     len, idx;
        logic   w;
        bit     ended;
        longint last;
        len   = vals.size() * md;
        ended = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < p; i++) begin
            check_eq("prime_flags", 64'(flg), 64'(f_run(1'b0)));
            check_eq("prime_phi", 64'(nco_phi_inc), ms);
            tick();
        end
        check_eq("prime_flags", 64'(flg), 64'(f_run(1'b0)));
        nco_out_valid = 1'b1;
        tick();
        last = ms;
        for (int k = 0; k < 4000 && !ended; k++) begin
            cfg_valid = 1'b0;
            start     = 1'b0;
            if (!tone && mmode == 0 && k == len) begin
                check_eq("done_flags", 64'(flg), 64'(f_done()));
                check_eq("done_phi", 64'(nco_phi_inc), me);
                tick();
                check_eq("post_done_flags", 64'(flg), 64'(f_idle()));
                check_eq("post_done_phi", 64'(nco_phi_inc), me);
                ended = 1;
            end else begin
                idx  = (k / md) % vals.size();
                w    = (mmode == 1) && !tone && (k > 0) && (k % len == 0);
                last = vals[idx];
                check_eq("sweep_phi", 64'(nco_phi_inc), last);
                check_eq("sweep_flags", 64'(flg), 64'(f_run(w)));
                if (k == abort_at) begin
                    abort = 1'b1;
                    tick();
                    abort = 1'b0;
                    check_eq("abort_flags", 64'(flg), 64'(f_idle()));
                    check_eq("abort_phi", 64'(nco_phi_inc), last);
                    ended = 1;
                end else begin
                    nco_out_valid = 1'($urandom_range(0, 1));
                    if (junk) begin
                        cfg_valid = 1'($urandom_range(0, 1));
                        start     = 1'($urandom_range(0, 1));
                        cfg_start = $urandom;
                        cfg_stop  = $urandom;
                        cfg_step  = $urandom;
                        cfg_mode  = 1'($urandom_range(0, 1));
                    end
                    tick();
                end
            end
        end
        check_eq("sweep_ended", 64'(ended), 64'(1));
        nco_out_valid = 1'b0;
        cfg_valid     = 1'b0;
        start         = 1'b0;
    endtask

    task automatic run_timeout();
        start = 1'b1;
        tick();
        start         = 1'b0;
        nco_out_valid = 1'b0;
        for (int i = 0; i < int'(PRIME_TO); i++) begin
            check_eq("to_prime_flags", 64'(flg), 64'(f_run(1'b0)));
            tick();
        end
        m_err = 1'b1;
        check_eq("to_idle_flags", 64'(flg), 64'(f_idle()));
        check_eq("to_phi", 64'(nco_phi_inc), ms);
    endtask

    task automatic run_async_reset();
        do_cfg(32'd1000, 32'd2000, 32'd100, 16'd2, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start         = 1'b0;
        nco_out_valid = 1'b1;
        tick();
        tick();
        tick();
        check_eq("pre_reset_busy", 64'(busy), 64'(1));
        #2 reset = 1'b1;
        #1;
        m_err = 1'b0;
        check_eq("async_reset_flags", 64'(flg), 64'(f_idle()));
        check_eq("async_reset_phi", 64'(nco_phi_inc), 64'(0));
        tick();
        reset         = 1'b0;
        nco_out_valid = 1'b0;
        start         = 1'b1;
        tick();
        start = 1'b0;
        check_eq("start_after_reset_ignored", 64'(flg), 64'(f_idle()));
        tick();
        check_eq("start_after_reset_idle", 64'(flg), 64'(f_idle()));
    endtask

    initial begin
        logic [31:0] s, e, st;
        logic [15:0] dw;
        logic        md_i;
        longint      ls, le, diff;
        int          n, ab;

        reset         = 1'b0;
        cfg_valid     = 1'b0;
        cfg_start     = '0;
        cfg_stop      = '0;
        cfg_step      = '0;
        cfg_dwell     = '0;
        cfg_mode      = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        nco_out_valid = 1'b0;
        m_err         = 1'b0;
        ms = 0; me = 0; mst = 0; md = 1; mmode = 0;

        #1 reset = 1'b1;
        #2;
        check_eq("reset_flags", 64'(flg), 64'(f_idle()));
        check_eq("reset_phi", 64'(nco_phi_inc), 64'(0));
        tick();
        tick();
        reset = 1'b0;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_eq("start_without_cfg", 64'(flg), 64'(f_idle()));

        do_cfg(32'd100, 32'd130, 32'd10, 16'd3, 1'b0, 1'b1);
        run_sweep(9, -1, 1'b0);
        do_cfg(32'd100, 32'd130, 32'd10, 16'd3, 1'b0, 1'b0);
        run_sweep(2, 4, 1'b0);
        do_cfg(32'h10, 32'h03, 32'h05, 16'd0, 1'b0, 1'b0);
        run_sweep(3, -1, 1'b1);
        do_cfg(32'h10, 32'h00, 32'h20, 16'd0, 1'b0, 1'b0);
        run_sweep(1, -1, 1'b0);
        do_cfg(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd1, 1'b1, 1'b0);
        run_sweep(0, 7, 1'b1);
        do_cfg(32'd77, 32'd77, 32'd5, 16'd2, 1'b0, 1'b0);
        run_sweep(4, -1, 1'b0);
        do_cfg(32'd77, 32'd77, 32'd5, 16'd2, 1'b1, 1'b0);
        run_sweep(4, 9, 1'b0);

        do_cfg(32'd5, 32'd9, 32'd1, 16'd2, 1'b0, 1'b0);
        run_timeout();
        do_cfg(32'd5, 32'd9, 32'd1, 16'd2, 1'b0, 1'b0);
        run_sweep(5, -1, 1'b0);

        do_cfg(32'd50, 32'd80, 32'd0, 16'd4, 1'b0, 1'b0);
        run_sweep(2, 5, 1'b0);

        run_async_reset();

        for (int r = 0; r < 40; r++) begin
            s  = $urandom;
            e  = ($urandom_range(0, 3) == 0) ? s : $urandom;
            ls = {32'd0, s};
            le = {32'd0, e};
            diff = (ls <= le) ? le - ls : ls - le;
            n    = int'($urandom_range(1, 8));
            diff = diff / n + longint'($urandom_range(0, 3));
            if (diff > 64'sh0000_0000_FFFF_FFFF) diff = 64'sh0000_0000_FFFF_FFFF;
            st = 32'(diff);
            if ($urandom_range(0, 9) == 0) st = 32'd0;
            dw   = 16'($urandom_range(0, 4));
            md_i = 1'($urandom_range(0, 1));
            do_cfg(s, e, st, dw, md_i, 1'($urandom_range(0, 1)));
            if (tone || mmode == 1)
                ab = int'($urandom_range(0, 32'(3 * vals.size() * md + 2)));
            else if ($urandom_range(0, 3) == 0)
                ab = int'($urandom_range(0, 32'(vals.size() * md - 1)));
            else
                ab = -1;
            run_sweep(int'($urandom_range(0, 20)), ab, 1'b1);
            if (r % 13 == 12) begin
                run_timeout();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
